uart_cmd_rx: RTL and testbench

//  UART receiver and command-frame parser that feeds the ALU/UART-TX sequencer.

---
 rtl/uart_cmd_rx.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver plus a 4-byte command-frame parser.
// Frames are SYNC, OP, A, B. A good frame updates the registered a/b/opcode
// outputs and pulses cmd_valid for one cycle. A bad stop bit, an OP byte
// with any of bits [7:3] set, or an inter-byte timeout pulses frame_err.
// In each of those cases a/b/opcode keep their previous values.
module uart_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned TIMEOUT_CLKS = 20000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [2:0] opcode,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       rx_active
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_START = 2'd1,
    B_DATA  = 2'd2,
    B_STOP  = 2'd3
  } bit_state_e;

  typedef enum logic [1:0] {
    P_SYNC = 2'd0,
    P_OP   = 2'd1,
    P_A    = 2'd2,
    P_B    = 2'd3
  } parse_state_e;

  // Synchroniser and edge-detect history.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // Bit-level receiver state.
  bit_state_e       b_state_q, b_state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;

  // Frame parser state.
  parse_state_e     p_state_q, p_state_d;
  logic [2:0]       op_tmp_q, op_tmp_d;
  logic [7:0]       a_tmp_q, a_tmp_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Registered outputs.
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] opcode_q, opcode_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       rx_active_q, rx_active_d;

  // Events between the two FSMs.
  logic start_edge_s;
  logic byte_strobe_s;
  logic stop_err_s;
  logic timeout_s;

  assign a         = a_q;
  assign b         = b_q;
  assign opcode    = opcode_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign rx_active = rx_active_q;

  // A start edge only counts while the bit FSM is waiting for a new byte.
  assign start_edge_s = (b_state_q == B_IDLE) && rx_prev_q && !rx_sync_q;

  // Two-flop synchroniser on rx plus one flop of history for edge detection; idle is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Bit FSM state register with its bit-timing counter and shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b_state_q <= B_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      b_state_q <= b_state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Bit FSM next state: mid-bit sampling, LSB-first shift-in, stop-bit check.
  always_comb begin
    b_state_d     = b_state_q;
    clk_cnt_d     = clk_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    byte_strobe_s = 1'b0;
    stop_err_s    = 1'b0;
    case (b_state_q)
      B_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = 3'd0;
        if (start_edge_s) begin
          b_state_d = B_START;
        end else begin
          b_state_d = B_IDLE;
        end
      end
      B_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          if (rx_sync_q) begin
            // The line went high again before mid-start: a glitch, not a byte.
            b_state_d = B_IDLE;
          end else begin
            b_state_d = B_DATA;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      B_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            b_state_d = B_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      B_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          b_state_d = B_IDLE;
          if (rx_sync_q) begin
            byte_strobe_s = 1'b1;
          end else begin
            stop_err_s = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        b_state_d = B_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  // Inter-byte timeout counter. It runs only while a frame is open and the line is idle.
  // A start edge clears it, so a start edge beats a timeout in the same cycle.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    timeout_s = 1'b0;
    if ((p_state_q == P_SYNC) || start_edge_s) begin
      tmo_cnt_d = '0;
    end else if (b_state_q == B_IDLE) begin
      if (tmo_cnt_q == TMO_LAST) begin
        timeout_s = 1'b1;
        tmo_cnt_d = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Parser next state and output updates.
  // Errors take priority and can never coincide with a byte strobe.
  always_comb begin
    p_state_d   = p_state_q;
    op_tmp_d    = op_tmp_q;
    a_tmp_d     = a_tmp_q;
    a_d         = a_q;
    b_d         = b_q;
    opcode_d    = opcode_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    if (stop_err_s || timeout_s) begin
      frame_err_d = 1'b1;
      p_state_d   = P_SYNC;
    end else if (byte_strobe_s) begin
      case (p_state_q)
        P_SYNC: begin
          if (shift_q == SYNC_BYTE) begin
            p_state_d = P_OP;
          end else begin
            p_state_d = P_SYNC;
          end
        end
        P_OP: begin
          if (shift_q[7:3] != 5'd0) begin
            frame_err_d = 1'b1;
            p_state_d   = P_SYNC;
          end else begin
            op_tmp_d  = shift_q[2:0];
            p_state_d = P_A;
          end
        end
        P_A: begin
          a_tmp_d   = shift_q;
          p_state_d = P_B;
        end
        P_B: begin
          a_d         = a_tmp_q;
          b_d         = shift_q;
          opcode_d    = op_tmp_q;
          cmd_valid_d = 1'b1;
          p_state_d   = P_SYNC;
        end
        default: begin
          p_state_d = P_SYNC;
        end
      endcase
    end else begin
      p_state_d = p_state_q;
    end
    rx_active_d = (p_state_d != P_SYNC);
  end

  // Parser state, timeout counter, frame staging and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_state_q   <= P_SYNC;
      op_tmp_q    <= 3'd0;
      a_tmp_q     <= 8'h00;
      tmo_cnt_q   <= '0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      opcode_q    <= 3'd0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      rx_active_q <= 1'b0;
    end else begin
      p_state_q   <= p_state_d;
      op_tmp_q    <= op_tmp_d;
      a_tmp_q     <= a_tmp_d;
      tmo_cnt_q   <= tmo_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      opcode_q    <= opcode_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      rx_active_q <= rx_active_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx.
// Table rows drive byte sequences and give the expected held outputs and pulse counts.
// A frame-level reference parser queues the expected cmd_valid/frame_err events.
// Those events are popped and compared whenever the DUT pulses an output.
module tb_uart_cmd_rx;

  localparam int CPB = 16;
  localparam int TMO = 400;

  logic       clock;
  logic       reset;
  logic       rx;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;
  logic       cmd_valid;
  logic       frame_err;
  logic       rx_active;

  uart_cmd_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TMO),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .cmd_valid(cmd_valid),
    .frame_err(frame_err),
    .rx_active(rx_active)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [2:0] eop;
  } ev_t;

  typedef struct {
    logic [63:0] bytes;  // first byte in bits [63:56]
    int          n;
    bit          bad_last;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [2:0]  eop;
    int          ecmd;
    int          eerr;
  } vec_t;

  ev_t        exp_q[$];
  int         n_pass  = 0;
  int         n_total = 0;
  int         n_cmd   = 0;
  int         n_err   = 0;
  int         m_state = 0;
  logic [7:0] m_a     = 8'h00;
  logic [2:0] m_op    = 3'd0;
  vec_t       vecs[7];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // One clock; sample outputs 1ns after the edge and score any pulses.
  task automatic tick();
    ev_t e;
    @(posedge clock);
    #1;
    if (!reset) begin
      if (cmd_valid || frame_err) check("cmd_err_exclusive", int'(cmd_valid && frame_err), 0);
      if (cmd_valid) begin
        n_cmd++;
        check("cmd_was_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("cmd_event_kind", int'(e.is_err), 0);
          check("cmd_a", int'(a), int'(e.ea));
          check("cmd_b", int'(b), int'(e.eb));
          check("cmd_opcode", int'(opcode), int'(e.eop));
        end
      end
      if (frame_err) begin
        n_err++;
        check("err_was_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("err_event_kind", int'(e.is_err), 1);
        end
      end
    end
  endtask

  // Frame-level reference parser: queues the events one byte should cause.
  task automatic model_byte(input logic [7:0] d, input bit ok);
    ev_t e;
    if (!ok) begin
      e = '{1'b1, 8'h00, 8'h00, 3'd0};
      exp_q.push_back(e);
      m_state = 0;
    end else begin
      case (m_state)
        0: if (d == 8'hA5) m_state = 1;
        1: begin
          if (d[7:3] != 5'd0) begin
            e = '{1'b1, 8'h00, 8'h00, 3'd0};
            exp_q.push_back(e);
            m_state = 0;
          end else begin
            m_op    = d[2:0];
            m_state = 2;
          end
        end
        2: begin
          m_a     = d;
          m_state = 3;
        end
        3: begin
          e = '{1'b0, m_a, d, m_op};
          exp_q.push_back(e);
          m_state = 0;
        end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop_ok);
    model_byte(d, stop_ok);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) tick();
    end
    rx = stop_ok;
    repeat (CPB) tick();
    rx = 1'b1;
  endtask

  function automatic vec_t mk(input logic [63:0] bs, input int n, input bit bad,
                              input logic [7:0] ea, input logic [7:0] eb,
                              input logic [2:0] eop, input int ecmd, input int eerr);
    vec_t v;
    v.bytes = bs; v.n = n; v.bad_last = bad;
    v.ea = ea; v.eb = eb; v.eop = eop; v.ecmd = ecmd; v.eerr = eerr;
    return v;
  endfunction

  initial begin
    int         err_at;
    logic [7:0] byt;
    logic [7:0] partial;

    vecs[0] = mk(64'hA5021234_00000000, 4, 1'b0, 8'h12, 8'h34, 3'd2, 1, 0);
    vecs[1] = mk(64'h00FF13A5_07FF0100, 7, 1'b0, 8'hFF, 8'h01, 3'd7, 1, 0);
    vecs[2] = mk(64'hA50177_0000000000, 3, 1'b1, 8'hFF, 8'h01, 3'd7, 0, 1);
    vecs[3] = mk(64'hA508_000000000000, 2, 1'b0, 8'hFF, 8'h01, 3'd7, 0, 1);
    vecs[4] = mk(64'hA503AA55_00000000, 4, 1'b0, 8'hAA, 8'h55, 3'd3, 1, 0);
    vecs[5] = mk(64'hA5060102_A5007F80, 8, 1'b0, 8'h7F, 8'h80, 3'd0, 2, 0);
    vecs[6] = mk(64'hA505A5A5_00000000, 4, 1'b0, 8'hA5, 8'hA5, 3'd5, 1, 0);

    // Reset state
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) tick();
    check("rst_a", int'(a), 0);
    check("rst_b", int'(b), 0);
    check("rst_opcode", int'(opcode), 0);
    check("rst_cmd_valid", int'(cmd_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_rx_active", int'(rx_active), 0);
    reset = 1'b0;
    repeat (4) tick();

    // Table-driven byte sequences
    for (int r = 0; r < 7; r++) begin
      n_cmd = 0;
      n_err = 0;
      for (int i = 0; i < vecs[r].n; i++) begin
        byt = vecs[r].bytes[63 - 8 * i -: 8];
        send_byte(byt, !(vecs[r].bad_last && (i == vecs[r].n - 1)));
      end
      repeat (3 * CPB) tick();
      check($sformatf("row%0d_a", r), int'(a), int'(vecs[r].ea));
      check($sformatf("row%0d_b", r), int'(b), int'(vecs[r].eb));
      check($sformatf("row%0d_opcode", r), int'(opcode), int'(vecs[r].eop));
      check($sformatf("row%0d_cmd_count", r), n_cmd, vecs[r].ecmd);
      check($sformatf("row%0d_err_count", r), n_err, vecs[r].eerr);
      check($sformatf("row%0d_queue_empty", r), exp_q.size(), 0);
      check($sformatf("row%0d_rx_active", r), int'(rx_active), 0);
    end

    // A short low glitch on rx produces no byte and no error.
    n_cmd = 0;
    n_err = 0;
    rx = 1'b0;
    repeat (CPB / 4) tick();
    rx = 1'b1;
    repeat (3 * CPB) tick();
    check("glitch_cmd_count", n_cmd, 0);
    check("glitch_err_count", n_err, 0);
    check("glitch_rx_active", int'(rx_active), 0);

    // A partial frame followed by silence gives exactly one timeout error.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    check("partial_rx_active", int'(rx_active), 1);
    exp_q.push_back('{1'b1, 8'h00, 8'h00, 3'd0});
    m_state = 0;
    err_at  = -1;
    for (int t = 0; t < TMO + 10; t++) begin
      tick();
      if ((n_err != 0) && (err_at < 0)) err_at = t;
    end
    check("timeout_err_count", n_err, 1);
    check("timeout_window", int'((err_at >= TMO - CPB) && (err_at <= TMO)), 1);
    check("timeout_rx_active", int'(rx_active), 0);
    check("timeout_a_held", int'(a), 8'hA5);
    check("timeout_opcode_held", int'(opcode), 5);
    check("timeout_queue_empty", exp_q.size(), 0);

    // Reset in the middle of the B byte, then a clean frame.
    n_cmd = 0;
    n_err = 0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h10, 1'b1);
    partial = 8'h20;
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      repeat (CPB) tick();
    end
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) tick();
    exp_q.delete();
    m_state = 0;
    check("midrst_a", int'(a), 0);
    check("midrst_b", int'(b), 0);
    check("midrst_opcode", int'(opcode), 0);
    check("midrst_cmd_valid", int'(cmd_valid), 0);
    check("midrst_rx_active", int'(rx_active), 0);
    reset = 1'b0;
    repeat (2 * CPB) tick();
    check("postrst_cmd_count", n_cmd, 0);
    check("postrst_err_count", n_err, 0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h21, 1'b1);
    send_byte(8'h43, 1'b1);
    repeat (3 * CPB) tick();
    check("postrst_frame_cmd_count", n_cmd, 1);
    check("postrst_frame_a", int'(a), 8'h21);
    check("postrst_frame_b", int'(b), 8'h43);
    check("postrst_frame_opcode", int'(opcode), 5);
    check("postrst_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
